// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: fetch FSM state encoding and the NOP word used for IF/ID flushes.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_ctrl_hazard_detect.sv
// Load-use comparator: flags a load in EX whose destination feeds ID. Purely combinational.
module hazard_detect (
  input  logic       mem_read,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: arbitrates branch redirect, load-use stall and imem wait states.
// Outputs are Mealy (zero-cycle stall latency); the PC is frozen while an imem request is outstanding.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  pc_branch,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             pc_write,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t          state;
  logic [XLEN-1:0] redirect_pc;
  logic            load_use;

  hazard_detect u_hazard_detect (
    .mem_read (id_ex_mem_read),
    .rd       (id_ex_rd),
    .rs1      (if_id_rs1),
    .rs2      (if_id_rs2),
    .load_use (load_use)
  );

  always_comb begin
    imem_req    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = 1'b0;
    pc_target   = '0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!reset) begin
      case (state)
        S_BOOT: pc_target = pc_branch;
        S_FETCH: begin
          imem_req  = 1'b1;
          pc_target = pc_branch;
          if (branch_taken) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            // Without a ready word the redirect is deferred to S_DRAIN.
            if (imem_ready) begin
              pc_write = 1'b1;
              pc_sel   = 1'b1;
            end
          end else if (load_use) begin
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        S_DRAIN: begin
          imem_req    = 1'b1;
          pc_target   = redirect_pc;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          if (imem_ready) begin
            pc_write = 1'b1;
            pc_sel   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_BOOT;
      redirect_pc  <= '0;
      stall_cycles <= '0;
    end else begin
      case (state)
        S_BOOT:  state <= S_FETCH;
        S_FETCH: begin
          if (branch_taken && !imem_ready) begin
            redirect_pc <= pc_branch;
            state       <= S_DRAIN;
          end
        end
        S_DRAIN: if (imem_ready) state <= S_FETCH;
        default: state <= S_BOOT;
      endcase
      if (!pc_write && state != S_BOOT && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl; the driver queues hand-computed expectations, a negedge monitor checks them.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [31:0] pc_branch;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd, if_id_rs1, if_id_rs2;
  logic        imem_ready;
  logic        imem_req, pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush;
  logic [31:0] pc_target;
  logic [3:0]  stall_cycles;

  fetch_ctrl #(.XLEN(32), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .branch_taken   (branch_taken),
    .pc_branch      (pc_branch),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2),
    .imem_ready     (imem_ready),
    .imem_req       (imem_req),
    .pc_write       (pc_write),
    .pc_sel         (pc_sel),
    .pc_target      (pc_target),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ctl;   // {imem_req, pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush}
    logic [31:0] tgt;
    logic [3:0]  stall;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [3:0] exp_stall = 4'd0;

  // ctl fields: expected controls; expected stall count is tracked by hand-rule below.
  task automatic step(input logic rst, input logic br, input logic [31:0] pcb,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic rdy,
                      input logic [5:0] ctl, input logic [31:0] tgt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; branch_taken = br; pc_branch = pcb; id_ex_mem_read = mr;
    id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2; imem_ready = rdy;
    e.ctl = ctl; e.tgt = tgt; e.stall = exp_stall; e.nm = nm;
    exp_q.push_back(e);
    if (rst) exp_stall = 4'd0;
    else if (ctl[5] && !ctl[4] && exp_stall != 4'd15) exp_stall = exp_stall + 4'd1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [5:0] act;
      e = exp_q.pop_front();
      act = {imem_req, pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush};
      total++;
      if (act !== e.ctl || pc_target !== e.tgt || stall_cycles !== e.stall) begin
        bad++;
        $display("FAIL %s: ctl=%b tgt=%h stall=%0d, required ctl=%b tgt=%h stall=%0d",
                 e.nm, act, pc_target, stall_cycles, e.ctl, e.tgt, e.stall);
      end
      total++;
      if ((pc_sel && !pc_write) || (if_id_write && !imem_ready && !pc_write && !if_id_flush)) begin
        bad++;
        $display("FAIL %s invariant: pc_sel=%b pc_write=%b if_id_write=%b if_id_flush=%b",
                 e.nm, pc_sel, pc_write, if_id_write, if_id_flush);
      end
    end
  end

  initial begin
    reset = 1'b1; branch_taken = 1'b0; pc_branch = '0; id_ex_mem_read = 1'b0;
    id_ex_rd = '0; if_id_rs1 = '0; if_id_rs2 = '0; imem_ready = 1'b0;
    repeat (2) @(posedge clk);

    step(1, 0, 32'h0,   0, 0, 0, 0, 1, 6'b000000, 32'h0,   "reset");
    step(0, 0, 32'h0,   0, 0, 0, 0, 1, 6'b000000, 32'h0,   "boot");
    for (int i = 0; i < 10; i++)
      step(0, 0, 32'(i * 4), 0, 0, 0, 0, 1, 6'b110100, 32'(i * 4), "stream");
    step(0, 0, 32'h0,   1, 5, 0, 5, 1, 6'b100001, 32'h0,   "load_use_rs2");
    step(0, 0, 32'h0,   1, 0, 0, 0, 1, 6'b110100, 32'h0,   "load_x0");
    step(0, 0, 32'h0,   1, 7, 7, 3, 0, 6'b100001, 32'h0,   "load_use_rs1_wait");
    step(0, 0, 32'h0,   0, 0, 0, 0, 0, 6'b100110, 32'h0,   "imem_wait");
    step(0, 1, 32'h100, 0, 0, 0, 0, 1, 6'b111111, 32'h100, "branch_ready");
    step(0, 1, 32'h104, 1, 9, 9, 0, 1, 6'b111111, 32'h104, "branch_and_load_use");
    step(0, 1, 32'h200, 0, 0, 0, 0, 0, 6'b100111, 32'h200, "branch_wait");
    step(0, 0, 32'h300, 0, 0, 0, 0, 0, 6'b100110, 32'h200, "drain_hold");
    step(0, 1, 32'h400, 1, 4, 4, 4, 0, 6'b100110, 32'h200, "drain_ignore");
    step(0, 0, 32'h500, 0, 0, 0, 0, 1, 6'b111110, 32'h200, "drain_ready");
    step(0, 0, 32'h600, 0, 0, 0, 0, 1, 6'b110100, 32'h600, "after_drain");
    for (int i = 0; i < 20; i++)
      step(0, 0, 32'h0, 0, 0, 0, 0, 0, 6'b100110, 32'h0, "saturate");
    step(0, 1, 32'h40,  0, 0, 0, 0, 0, 6'b100111, 32'h40,  "branch_before_reset");
    step(1, 1, 32'h40,  0, 0, 0, 0, 1, 6'b000000, 32'h0,   "reset_mid_drain");
    step(0, 0, 32'h0,   0, 0, 0, 0, 1, 6'b000000, 32'h0,   "boot_after_reset");
    step(0, 0, 32'h8,   0, 0, 0, 0, 1, 6'b110100, 32'h8,   "fetch_after_reset");

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: pending=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
